// File: rtl/osc_freq_monitor.sv
// Oscillator frequency monitor.
// Counts synchronised rising edges of MON_CLK over a fixed window of CLK cycles.
// Each completed window publishes the count and an in/out-of-tolerance verdict.
// The verdict is kept as a level (FREQ_OK) and as a sticky failure flag (FREQ_FAIL).
module osc_freq_monitor #(
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned EXP_COUNT     = 1000,
  parameter int unsigned TOL           = 20,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             MON_CLK,
  input  logic             ENABLE,
  input  logic             CLEAR_FAIL,
  output logic [CNT_W-1:0] COUNT,
  output logic             COUNT_VALID,
  output logic             FREQ_OK,
  output logic             FREQ_FAIL,
  output logic             BUSY
);

  localparam int unsigned WinW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW_CYCLES - 1);
  // Tolerance bounds carry one extra bit so EXP_COUNT + TOL cannot wrap.
  localparam logic [CNT_W:0]   CntLo   = (CNT_W + 1)'(EXP_COUNT - TOL);
  localparam logic [CNT_W:0]   CntHi   = (CNT_W + 1)'(EXP_COUNT + TOL);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StEval
  } state_e;

  state_e           state_q;
  logic [WinW-1:0]  win_q;
  logic [CNT_W-1:0] edge_q;
  logic             s1_q, s2_q, s3_q;
  logic             edge_det;
  logic [CNT_W:0]   cnt_ext;
  logic             in_range;

  // s3 follows s2 in every state, so an input already high when a window opens
  // never looks like a fresh edge.
  assign edge_det = s2_q & ~s3_q;
  assign cnt_ext  = {1'b0, edge_q};
  assign in_range = (cnt_ext >= CntLo) && (cnt_ext <= CntHi);

  // Two-flop synchroniser for MON_CLK plus a history flop for edge detection.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= MON_CLK;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Window sequencing, edge counting and registered result outputs.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= StIdle;
      win_q       <= '0;
      edge_q      <= '0;
      COUNT       <= '0;
      COUNT_VALID <= 1'b0;
      FREQ_OK     <= 1'b0;
      FREQ_FAIL   <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      COUNT_VALID <= 1'b0;
      // A failing evaluation below overrides this clear in the same cycle.
      if (CLEAR_FAIL) begin
        FREQ_FAIL <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          win_q  <= '0;
          edge_q <= '0;
          if (ENABLE) begin
            state_q <= StMeasure;
            BUSY    <= 1'b1;
          end
        end
        StMeasure: begin
          if (!ENABLE) begin
            // Abort: drop the partial window, results keep their old values.
            state_q <= StIdle;
            BUSY    <= 1'b0;
            win_q   <= '0;
            edge_q  <= '0;
          end else begin
            win_q <= win_q + 1'b1;
            if (edge_det && (edge_q != CntMax)) begin
              edge_q <= edge_q + 1'b1;
            end
            if (win_q == WinLast) begin
              state_q <= StEval;
            end
          end
        end
        StEval: begin
          COUNT       <= edge_q;
          COUNT_VALID <= 1'b1;
          FREQ_OK     <= in_range;
          if (!in_range) begin
            FREQ_FAIL <= 1'b1;
          end
          win_q  <= '0;
          edge_q <= '0;
          if (ENABLE) begin
            state_q <= StMeasure;
          end else begin
            state_q <= StIdle;
            BUSY    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Bench for osc_freq_monitor: directed scenarios plus a randomised run, every
// cycle checked against a window-schedule reference model.
`timescale 1ns / 1ps
module tb_osc_freq_monitor;

  localparam int W    = 1000;
  localparam int EXP  = 20;
  localparam int TOLR = 2;
  localparam int CW   = 16;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          mon   = 1'b0;
  logic          en    = 1'b0;
  logic          clr   = 1'b0;
  logic [CW-1:0] count;
  logic          valid, ok, fail, busy;

  logic          sat_mon = 1'b0;
  logic [3:0]    sat_count;
  logic          sat_valid, sat_ok, sat_fail, sat_busy;

  int vectors     = 0;
  int miscompares = 0;
  int n           = 0;

  // Reference model: ph = -1 idle, 0..W-1 position in window, W evaluation cycle.
  int ph      = -1;
  int m_edges = 0;
  int e_count = 0;
  bit e_valid = 1'b0;
  bit e_ok    = 1'b0;
  bit e_fail  = 1'b0;
  int rises[$];  // cycle in which each MON_CLK rise reaches the edge detector

  int mon_mode  = 0;  // 0 toggling, 1 stuck low, 2 stuck high
  int half_lo   = 25;
  int half_hi   = 25;
  int mon_timer = 25;
  int last_valid_n = -1;
  int valid_gap    = 0;
  int sat_seen     = 0;
  bit clr_at_eval  = 1'b0;

  osc_freq_monitor #(
    .WINDOW_CYCLES(W), .EXP_COUNT(EXP), .TOL(TOLR), .CNT_W(CW)
  ) u_dut (
    .CLK(clk), .RESETN(rst_n), .MON_CLK(mon), .ENABLE(en), .CLEAR_FAIL(clr),
    .COUNT(count), .COUNT_VALID(valid), .FREQ_OK(ok), .FREQ_FAIL(fail), .BUSY(busy)
  );

  osc_freq_monitor #(
    .WINDOW_CYCLES(W), .EXP_COUNT(10), .TOL(2), .CNT_W(4)
  ) u_sat (
    .CLK(clk), .RESETN(rst_n), .MON_CLK(sat_mon), .ENABLE(1'b1), .CLEAR_FAIL(1'b0),
    .COUNT(sat_count), .COUNT_VALID(sat_valid), .FREQ_OK(sat_ok), .FREQ_FAIL(sat_fail),
    .BUSY(sat_busy)
  );

  always #10 clk = ~clk;  // 50 MHz

  initial begin
    #3;
    forever #50 sat_mon = ~sat_mon;  // 10 MHz, free-running
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", tag, n, act, exp);
    end
  endtask

  task automatic model_step(input bit en_s, input bit clr_s, input bit rst_s);
    if (!rst_s) begin
      ph = -1; m_edges = 0; e_count = 0; e_valid = 0; e_ok = 0; e_fail = 0;
      rises.delete();
    end else begin
      e_valid = (ph == W);
      if (ph == W) begin
        e_count = m_edges;
        e_ok    = (m_edges >= EXP - TOLR) && (m_edges <= EXP + TOLR);
      end
      if (clr_s) e_fail = 0;
      if (ph == W && !e_ok) e_fail = 1;
      if (ph == -1 || ph == W) ph = en_s ? 0 : -1;
      else if (!en_s)          ph = -1;
      else                     ph = ph + 1;
      if (ph <= 0) m_edges = 0;
    end
    while (rises.size() > 0 && rises[0] <= n) begin
      if (rises[0] == n && ph >= 0 && ph < W && m_edges < SAT) m_edges++;
      void'(rises.pop_front());
    end
  endtask

  task automatic mon_drive();
    case (mon_mode)
      0: begin
        if (mon_timer <= 1) begin
          mon = ~mon;
          mon_timer = $urandom_range(half_hi, half_lo);
          if (mon && rst_n) rises.push_back(n + 2);
        end else begin
          mon_timer--;
        end
      end
      1: mon = 1'b0;
      default: begin
        if (!mon && rst_n) rises.push_back(n + 2);
        mon = 1'b1;
      end
    endcase
  endtask

  task automatic set_mon(input int lo, input int hi);
    half_lo = lo; half_hi = hi; mon_mode = 0; mon_timer = lo;
  endtask

  // One CLK cycle: inputs set now are sampled at the coming rising edge.
  task automatic tick();
    bit en_s, clr_s, rst_s;
    en_s = en; clr_s = clr; rst_s = rst_n;
    @(negedge clk);
    n++;
    clr = 1'b0;
    model_step(en_s, clr_s, rst_s);
    chk("count", count, e_count);
    chk("count_valid", valid, e_valid);
    chk("freq_ok", ok, e_ok);
    chk("freq_fail", fail, e_fail);
    chk("busy", busy, ph != -1);
    if (valid) begin
      if (last_valid_n >= 0) valid_gap = n - last_valid_n;
      last_valid_n = n;
    end
    if (sat_valid) begin
      chk("sat_count", sat_count, 15);
      chk("sat_ok", sat_ok, 0);
      chk("sat_fail", sat_fail, 1);
      sat_seen++;
    end
    mon_drive();
    if (clr_at_eval && ph == W) begin
      clr = 1'b1;
      clr_at_eval = 1'b0;
    end
  endtask

  task automatic run_results(input int k, input bit do_range, input int lo_c, input int hi_c,
                             input bit do_gap);
    int got = 0;
    int budget = k * (W + 1) + W + 50;
    while (got < k && budget > 0) begin
      tick();
      budget--;
      if (e_valid) begin
        got++;
        if (do_range) chk("count_range", (count >= lo_c) && (count <= hi_c), 1);
        if (do_gap && got > 1) chk("period", valid_gap, W + 1);
      end
    end
    if (got < k) chk("result_timeout", got, k);
  endtask

  task automatic wait_dut_valid(input int budget, output int nv);
    nv = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid) begin
        nv = n;
        break;
      end
    end
    if (nv < 0) chk("valid_timeout", 0, 1);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    if (mon) rises.push_back(n + 2);
  endtask

  initial begin
    int nv, n0, lo, saved_count;
    bit saved_ok;

    // Reset state
    repeat (3) tick();
    release_reset();

    // Nominal 1 MHz
    set_mon(25, 25);
    en = 1'b1;
    run_results(3, 1, 19, 21, 1);

    // 1.5 MHz: out of tolerance
    set_mon(16, 17);
    run_results(1, 0, 0, 0, 0);
    run_results(2, 1, 29, 31, 0);
    chk("fail_set", fail, 1);

    // Back to 1 MHz: OK recovers, FAIL stays
    set_mon(25, 25);
    run_results(1, 0, 0, 0, 0);
    run_results(1, 1, 19, 21, 0);
    chk("ok_recover", ok, 1);
    chk("fail_sticky", fail, 1);

    // CLEAR_FAIL pulse
    clr = 1'b1;
    tick();
    chk("clear_fail", fail, 0);

    // CLEAR_FAIL coinciding with a failing evaluation
    set_mon(16, 17);
    run_results(1, 0, 0, 0, 0);
    clr = 1'b1;
    tick();
    clr_at_eval = 1'b1;
    run_results(1, 1, 29, 31, 0);
    chk("clr_vs_set", fail, 1);

    // Stuck low
    mon_mode = 1;
    run_results(1, 0, 0, 0, 0);
    run_results(1, 0, 0, 0, 0);
    chk("stuck_lo_count", count, 0);
    chk("stuck_lo_ok", ok, 0);
    chk("stuck_lo_fail", fail, 1);

    // Stuck high from before ENABLE
    en = 1'b0;
    tick();
    mon_mode = 2;
    repeat (10) tick();
    en = 1'b1;
    run_results(1, 0, 0, 0, 0);
    chk("stuck_hi_count", count, 0);

    // Abort 500 cycles into a window, then re-enable
    set_mon(25, 25);
    run_results(1, 0, 0, 0, 0);
    run_results(1, 1, 19, 21, 0);
    saved_count = e_count;
    saved_ok = e_ok;
    repeat (499) tick();
    en = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_count", count, saved_count);
    chk("abort_ok", ok, saved_ok);
    repeat (20) tick();
    n0 = n;
    en = 1'b1;
    wait_dut_valid(2 * W, nv);
    chk("reenable_latency", nv - (n0 + 1), W + 1);

    // Randomised run
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 299) == 0) clr = 1'b1;
      if (en && $urandom_range(0, 2999) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
      tick();
      if (e_valid && $urandom_range(0, 1) == 0) begin
        lo = $urandom_range(30, 14);
        if ($urandom_range(0, 7) == 0) mon_mode = 1;
        else set_mon(lo, lo + $urandom_range(3, 0));
      end
    end

    // Reset 300 cycles into a window
    en = 1'b1;
    set_mon(25, 25);
    wait_dut_valid(3 * W, nv);
    repeat (300) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", valid, 0);
    chk("arst_ok", ok, 0);
    chk("arst_fail", fail, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sat_count", sat_count, 0);
    chk("arst_sat_fail", sat_fail, 0);
    chk("arst_sat_busy", sat_busy, 0);
    repeat (3) tick();
    release_reset();
    n0 = n;
    wait_dut_valid(2 * W, nv);
    chk("reset_latency", nv - (n0 + 1), W + 1);
    repeat (5) tick();

    chk("sat_seen", sat_seen > 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
